// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses one received KEY=VALUE payload into a packed key
// and a signed 32-bit value, or reports why the payload was rejected.
// One payload byte is examined per cycle; results leave as single-cycle pulses.
module uart_cmd_parser #(
  parameter int unsigned MAX_BYTES = 128
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [8*MAX_BYTES-1:0] rx_string,
  input  logic [7:0]             rx_length,
  input  logic                   rx_done,
  output logic                   busy,
  output logic [31:0]            cmd_key,
  output logic [31:0]            cmd_value,
  output logic                   cmd_valid,
  output logic                   cmd_err,
  output logic [2:0]             err_code
);

  localparam int unsigned STR_W  = 8 * MAX_BYTES;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned KEY_W  = 32;
  localparam int unsigned VAL_W  = 32;
  localparam int unsigned ACC_W  = 34;
  // Product is formed wider than the accumulator so the range compare
  // always sees the true value of acc*10+digit, never a wrapped one.
  localparam int unsigned PROD_W = ACC_W + 4;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] E_OK       = 3'd0;
  localparam logic [CODE_W-1:0] E_EMPTY    = 3'd1;
  localparam logic [CODE_W-1:0] E_TOO_LONG = 3'd2;
  localparam logic [CODE_W-1:0] E_BAD_KEY  = 3'd3;
  localparam logic [CODE_W-1:0] E_NO_EQ    = 3'd4;
  localparam logic [CODE_W-1:0] E_BAD_VAL  = 3'd5;
  localparam logic [CODE_W-1:0] E_OVERFLOW = 3'd6;

  localparam logic [PROD_W-1:0] POS_LIMIT = 38'd2147483647;
  localparam logic [PROD_W-1:0] NEG_LIMIT = 38'd2147483648;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PARSE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STR_W-1:0]    str_q, str_d;      // payload, shifted so the current byte is at [7:0]
  logic [LEN_W-1:0]    rem_q, rem_d;      // bytes still to examine, current one included
  logic [KEY_W-1:0]    key_q, key_d;
  logic [2:0]          kcnt_q, kcnt_d;
  logic                val_ph_q, val_ph_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                dig_q, dig_d;      // at least one value digit seen

  logic                busy_q, busy_d;
  logic [KEY_W-1:0]    cmd_key_q, cmd_key_d;
  logic [VAL_W-1:0]    cmd_value_q, cmd_value_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_err_q, cmd_err_d;
  logic [CODE_W-1:0]   err_code_q, err_code_d;

  logic [7:0]          byte_c;
  logic                is_key_c;
  logic                is_dig_c;
  logic [PROD_W-1:0]   prod_c;
  logic                fail_c;
  logic [CODE_W-1:0]   code_c;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    str_d       = str_q;
    rem_d       = rem_q;
    key_d       = key_q;
    kcnt_d      = kcnt_q;
    val_ph_d    = val_ph_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    dig_d       = dig_q;
    cmd_key_d   = cmd_key_q;
    cmd_value_d = cmd_value_q;
    err_code_d  = err_code_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    fail_c      = 1'b0;
    code_c      = E_OK;

    byte_c   = str_q[7:0];
    is_key_c = (byte_c inside {[8'h41:8'h5A], [8'h30:8'h39], 8'h5F});
    is_dig_c = (byte_c inside {[8'h30:8'h39]});
    prod_c   = PROD_W'(acc_q) * PROD_W'(10) + PROD_W'(byte_c[3:0]);

    case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          str_d    = rx_string;
          rem_d    = rx_length;
          key_d    = '0;
          kcnt_d   = '0;
          val_ph_d = 1'b0;
          acc_d    = '0;
          neg_d    = 1'b0;
          dig_d    = 1'b0;
          if (rx_length == '0) begin
            fail_c = 1'b1;
            code_c = E_EMPTY;
          end else if (32'(rx_length) > MAX_BYTES) begin
            fail_c = 1'b1;
            code_c = E_TOO_LONG;
          end else begin
            state_d = S_PARSE;
          end
        end
      end

      S_PARSE: begin
        str_d = str_q >> 8;
        rem_d = rem_q - LEN_W'(1);
        if (!val_ph_q) begin
          if (is_key_c) begin
            if (kcnt_q == 3'd4) begin
              fail_c = 1'b1;
              code_c = E_BAD_KEY;
            end else begin
              key_d  = {key_q[KEY_W-9:0], byte_c};
              kcnt_d = kcnt_q + 3'd1;
            end
          end else if (byte_c == 8'h3D && kcnt_q != 3'd0) begin
            val_ph_d = 1'b1;
          end else begin
            fail_c = 1'b1;
            code_c = E_BAD_KEY;
          end
        end else begin
          if (byte_c == 8'h2D) begin
            if (neg_q || dig_q) begin
              fail_c = 1'b1;
              code_c = E_BAD_VAL;
            end else begin
              neg_d = 1'b1;
            end
          end else if (is_dig_c) begin
            if (prod_c > (neg_q ? NEG_LIMIT : POS_LIMIT)) begin
              fail_c = 1'b1;
              code_c = E_OVERFLOW;
            end else begin
              acc_d = prod_c[ACC_W-1:0];
              dig_d = 1'b1;
            end
          end else begin
            fail_c = 1'b1;
            code_c = E_BAD_VAL;
          end
        end

        // End of payload: judge the command as a whole.
        if (!fail_c && rem_q == LEN_W'(1)) begin
          if (!val_ph_d) begin
            fail_c = 1'b1;
            code_c = E_NO_EQ;
          end else if (!dig_d) begin
            fail_c = 1'b1;
            code_c = E_BAD_VAL;
          end else begin
            state_d     = S_DONE;
            cmd_valid_d = 1'b1;
            cmd_key_d   = key_d;
            cmd_value_d = neg_d ? (VAL_W'(0) - acc_d[VAL_W-1:0]) : acc_d[VAL_W-1:0];
            err_code_d  = E_OK;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail_c) begin
      state_d    = S_ERR;
      cmd_err_d  = 1'b1;
      err_code_d = code_c;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      str_q       <= '0;
      rem_q       <= '0;
      key_q       <= '0;
      kcnt_q      <= '0;
      val_ph_q    <= 1'b0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      dig_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_key_q   <= '0;
      cmd_value_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      str_q       <= str_d;
      rem_q       <= rem_d;
      key_q       <= key_d;
      kcnt_q      <= kcnt_d;
      val_ph_q    <= val_ph_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      dig_q       <= dig_d;
      busy_q      <= busy_d;
      cmd_key_q   <= cmd_key_d;
      cmd_value_q <= cmd_value_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy      = busy_q;
  assign cmd_key   = cmd_key_q;
  assign cmd_value = cmd_value_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with hand-computed results,
// then random frames compared every cycle against a string-level model.
module tb_uart_cmd_parser;

  localparam int MAXB = 128;

  typedef struct packed {
    logic        ok;
    logic [2:0]  code;
    logic [31:0] key;
    logic [31:0] val;
    logic [15:0] lat;   // cycles from the accepted rx_done cycle to the pulse
  } res_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [8*MAXB-1:0] rx_string;
  logic [7:0]        rx_length;
  logic              rx_done;
  logic              busy;
  logic [31:0]       cmd_key;
  logic [31:0]       cmd_value;
  logic              cmd_valid;
  logic              cmd_err;
  logic [2:0]        err_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic [2:0]  m_code  = '0;
  logic [31:0] m_key   = '0;
  logic [31:0] m_val   = '0;
  int          m_cnt   = 0;
  res_t        m_res   = '0;

  uart_cmd_parser #(.MAX_BYTES(MAXB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_string (rx_string),
    .rx_length (rx_length),
    .rx_done   (rx_done),
    .busy      (busy),
    .cmd_key   (cmd_key),
    .cmd_value (cmd_value),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .err_code  (err_code)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic bit is_key_ch(input byte unsigned c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h30 && c <= 8'h39) || c == 8'h5F;
  endfunction

  function automatic res_t mk_err(input int code, input int j);
    res_t r;
    r      = '0;
    r.code = 3'(code);
    r.lat  = 16'(j + 2);
    return r;
  endfunction

  // Whole-string interpretation of a payload: split at '=', check key, evaluate number.
  function automatic res_t model_parse(input logic [8*MAXB-1:0] s, input int len);
    res_t         r;
    byte unsigned b[256];
    int           n, p;
    bit           neg, any;
    longint       v, lim;
    r = '0;
    if (len == 0)    return mk_err(1, -1);
    if (len > MAXB)  return mk_err(2, -1);
    for (int k = 0; k < len; k++) b[k] = s[8*k +: 8];
    n = 0;
    while (n < len && n < 5 && is_key_ch(b[n])) n++;
    if (n == 5)                  return mk_err(3, 4);
    if (n == len)                return mk_err(4, len - 1);
    if (n == 0 || b[n] != 8'h3D) return mk_err(3, n);
    p = n + 1;
    neg = 1'b0;
    if (p < len && b[p] == 8'h2D) begin
      neg = 1'b1;
      p++;
    end
    lim = neg ? 64'd2147483648 : 64'd2147483647;
    v   = 0;
    any = 1'b0;
    for (int i = p; i < len; i++) begin
      if (b[i] < 8'h30 || b[i] > 8'h39) return mk_err(5, i);
      v   = v * 10 + longint'(b[i] - 8'h30);
      any = 1'b1;
      if (v > lim) return mk_err(6, i);
    end
    if (!any) return mk_err(5, len - 1);
    r.ok  = 1'b1;
    for (int k = 0; k < n; k++) r.key = (r.key << 8) | 32'(b[k]);
    r.val = neg ? 32'(-v) : 32'(v);
    r.lat = 16'(len + 1);
    return r;
  endfunction

  function automatic logic [8*MAXB-1:0] pack(input string t);
    logic [8*MAXB-1:0] f;
    f = '0;
    for (int i = 0; i < t.len(); i++) f[8*i +: 8] = t[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference timeline: accepts a frame only when idle, pulses after the modelled latency.
  initial begin
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_cnt = 0; m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_code = '0; m_key = '0; m_val = '0;
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_busy && rx_done) begin
          m_res = model_parse(rx_string, int'(rx_length));
          m_cnt = int'(m_res.lat);
        end
        if (m_cnt > 0) begin
          m_cnt--;
          m_busy = 1'b1;
          if (m_cnt == 0) begin
            if (m_res.ok) begin
              m_valid = 1'b1; m_key = m_res.key; m_val = m_res.val; m_code = '0;
            end else begin
              m_err = 1'b1; m_code = m_res.code;
            end
          end
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the reference timeline.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        n_checks++;
        if ({busy, cmd_valid, cmd_err, err_code, cmd_key, cmd_value} !==
            {m_busy, m_valid, m_err, m_code, m_key, m_val}) begin
          n_fail++;
          $display("FAIL cycle_model t=%0t: got busy=%b valid=%b err=%b code=%0d key=%h val=%h, expected busy=%b valid=%b err=%b code=%0d key=%h val=%h",
                   $time, busy, cmd_valid, cmd_err, err_code, cmd_key, cmd_value,
                   m_busy, m_valid, m_err, m_code, m_key, m_val);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [8*MAXB-1:0] s, input int len);
    @(posedge sys_clk); #1;
    rx_string = s;
    rx_length = 8'(len);
    rx_done   = 1'b1;
    @(posedge sys_clk); #1;
    rx_done   = 1'b0;
  endtask

  // One frame with literal expectations for latency, code, key and value.
  task automatic run(input string name, input string txt, input int len, input int code,
                     input int lat, input logic [31:0] key, input logic [31:0] val);
    logic [8*MAXB-1:0] f;
    res_t r;
    int   k;
    bit   seen;
    f = pack(txt);
    r = model_parse(f, len);
    chk({name, "_model_lat"}, 32'(r.lat), 32'(lat));
    chk({name, "_model_code"}, 32'(r.code), 32'(code));
    send(f, len);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      k++;
      @(negedge sys_clk);
      seen = cmd_valid | cmd_err;
      chk({name, "_busy"}, 32'(busy), 32'd1);
    end
    chk({name, "_lat"}, seen ? 32'(k) : 32'd0, 32'(lat));
    chk({name, "_valid"}, 32'(cmd_valid), 32'(code == 0));
    chk({name, "_err"}, 32'(cmd_err), 32'(code != 0));
    chk({name, "_code"}, 32'(err_code), 32'(code));
    chk({name, "_key"}, cmd_key, key);
    chk({name, "_value"}, cmd_value, val);
    @(negedge sys_clk);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic gen_frame(output logic [8*MAXB-1:0] s, output logic [7:0] len);
    byte unsigned b[256];
    int    n, mode, klen, nd, pick;
    string kc, bad, dg;
    kc  = "ABMQZ019_";
    bad = "a+-=z. ";
    n = 0;
    for (int i = 0; i < MAXB / 4; i++) s[32*i +: 32] = $urandom();
    mode = int'($urandom_range(0, 9));
    if (mode == 0) begin
      len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(129, 255));
      return;
    end
    klen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 4));
    for (int i = 0; i < klen; i++) begin
      b[n] = kc[int'($urandom_range(0, kc.len() - 1))];
      n++;
    end
    if ($urandom_range(0, 9) != 0) begin b[n] = 8'h3D; n++; end
    if ($urandom_range(0, 3) == 0) begin b[n] = 8'h2D; n++; end
    if (mode == 1) begin
      pick = int'($urandom_range(0, 4));
      case (pick)
        0:       dg = "2147483647";
        1:       dg = "2147483648";
        2:       dg = "2147483649";
        3:       dg = "17179869190";
        default: dg = "4294967296";
      endcase
      for (int i = 0; i < dg.len(); i++) begin b[n] = dg[i]; n++; end
    end else if (mode == 2) begin
      nd = int'($urandom_range(60, 110));
      for (int i = 0; i < nd; i++) begin b[n] = 8'h30; n++; end
      b[n] = 8'h39; n++;
    end else begin
      nd = int'($urandom_range(0, 11));
      for (int i = 0; i < nd; i++) begin b[n] = 8'h30 + 8'($urandom_range(0, 9)); n++; end
    end
    if ($urandom_range(0, 7) == 0 && n > 0)
      b[int'($urandom_range(0, n - 1))] = bad[int'($urandom_range(0, bad.len() - 1))];
    for (int i = 0; i < n; i++) s[8*i +: 8] = b[i];
    len = 8'(n);
  endtask

  initial begin
    logic [8*MAXB-1:0] f;
    logic [7:0]        l;
    string             big;
    int                nvalid, nerr, at;

    rx_string = '0;
    rx_length = '0;
    rx_done   = 1'b0;
    sys_rst_n = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    chk_en    = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(cmd_valid), 32'd0);
    chk("reset_err", 32'(cmd_err), 32'd0);
    chk("reset_code", 32'(err_code), 32'd0);
    chk("reset_key", cmd_key, 32'd0);
    chk("reset_value", cmd_value, 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    run("freq",    "FREQ=1000",       9,  0, 10, 32'h46524551, 32'd1000);
    run("amp",     "AMP=-2147483648", 15, 0, 16, 32'h00414D50, 32'h80000000);
    run("ph_ovf",  "PH=2147483648",   13, 6, 14, 32'h00414D50, 32'h80000000);
    run("x1",      "X1=12a",          6,  5, 7,  32'h00414D50, 32'h80000000);
    run("abcde",   "ABCDE=1",         7,  3, 6,  32'h00414D50, 32'h80000000);
    run("lower",   "freq=1",          6,  3, 2,  32'h00414D50, 32'h80000000);
    run("nokey",   "=5",              2,  3, 2,  32'h00414D50, 32'h80000000);
    run("empty",   "",                0,  1, 1,  32'h00414D50, 32'h80000000);
    run("toolong", "JUNK",            129, 2, 1, 32'h00414D50, 32'h80000000);
    run("noeq",    "FREQ",            4,  4, 5,  32'h00414D50, 32'h80000000);
    run("k_eq",    "K=",              2,  5, 3,  32'h00414D50, 32'h80000000);
    run("k_neg",   "K=-",             3,  5, 4,  32'h00414D50, 32'h80000000);
    run("k_1m2",   "K=1-2",           5,  5, 5,  32'h00414D50, 32'h80000000);
    run("z9",      "Z_9=-17",         7,  0, 8,  32'h005A5F39, 32'hFFFFFFEF);
    big = "K=";
    repeat (125) big = {big, "0"};
    big = {big, "7"};
    run("max_len", big,               128, 0, 129, 32'h0000004B, 32'd7);
    run("wrap",    "V=17179869190",   13, 6, 14, 32'h0000004B, 32'd7);
    run("maxpos",  "V=2147483647",    12, 0, 13, 32'h00000056, 32'h7FFFFFFF);

    // Second rx_done while busy must be dropped.
    @(posedge sys_clk); #1;
    rx_string = pack("FREQ=1000"); rx_length = 8'd9; rx_done = 1'b1;   // T
    @(posedge sys_clk); #1; rx_done = 1'b0;                            // T+1
    @(posedge sys_clk); #1;                                            // T+2
    @(posedge sys_clk); #1;                                            // T+3
    rx_string = pack("B=1"); rx_length = 8'd3; rx_done = 1'b1;
    @(posedge sys_clk); #1; rx_done = 1'b0;                            // T+4
    nvalid = 0; nerr = 0; at = 0;
    for (int c = 4; c <= 11; c++) begin
      @(negedge sys_clk);
      if (cmd_valid) begin nvalid++; at = c; end
      if (cmd_err) nerr++;
    end
    chk("conc_nvalid", 32'(nvalid), 32'd1);
    chk("conc_at", 32'(at), 32'd10);
    chk("conc_nerr", 32'(nerr), 32'd0);
    chk("conc_key", cmd_key, 32'h46524551);
    run("conc_next", "K=5", 3, 0, 4, 32'h0000004B, 32'd5);

    // Reset in the middle of a parse.
    send(pack("FREQ=1000"), 9);
    repeat (3) begin @(posedge sys_clk); #1; end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_key", cmd_key, 32'd0);
    chk("midrst_value", cmd_value, 32'd0);
    chk("midrst_code", 32'(err_code), 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("midrst_nopulse", 32'({cmd_valid, cmd_err}), 32'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    run("k007", "K=007", 5, 0, 6, 32'h0000004B, 32'd7);

    // Random frames, many of them arriving while busy.
    repeat (3000) begin
      @(posedge sys_clk); #1;
      if ($urandom_range(0, 5) == 0) begin
        gen_frame(f, l);
        rx_string = f;
        rx_length = l;
        rx_done   = 1'b1;
      end else begin
        rx_done   = 1'b0;
      end
    end
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
    repeat (300) @(posedge sys_clk);
    @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
